// File: rtl/fir_pkg.sv
// Shared FIR-path definitions: sample width and the sample streamer FSM encoding.
package fir_pkg;

    localparam int unsigned DATA_W = 16;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_RD   = 3'd1,
        ST_LAT  = 3'd2,
        ST_OUT  = 3'd3,
        ST_DONE = 3'd4
    } state_e;

endpackage : fir_pkg

// File: rtl/bram_sample_streamer.sv
// Replays stored samples from a synchronous-read BRAM into the FIR input, one per tick.
module bram_sample_streamer
    import fir_pkg::*;
#(
    parameter int unsigned DATA_W = fir_pkg::DATA_W,
    parameter int unsigned ADDR_W = 10,
    parameter int unsigned DEPTH  = 1024,
    parameter int unsigned LOOP   = 1
) (
    input  logic              i_clk,
    input  logic              i_rstn,
    input  logic              i_tick,
    input  logic              i_enable,
    output logic              o_bram_en,
    output logic [ADDR_W-1:0] o_bram_addr,
    input  logic [DATA_W-1:0] i_bram_data,
    output logic [DATA_W-1:0] o_sample,
    output logic              o_valid,
    input  logic              i_ready,
    output logic              o_done,
    output logic              o_overrun
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    state_e              state_q,   state_d;
    logic [ADDR_W-1:0]   addr_q,    addr_d;
    logic                bram_en_q, bram_en_d;
    logic [DATA_W-1:0]   sample_q,  sample_d;
    logic                valid_q,   valid_d;
    logic                done_q,    done_d;
    logic                overrun_q, overrun_d;

    logic xfer_c;
    logic last_c;
    logic busy_c;

    assign xfer_c = valid_q & i_ready;
    assign last_c = (addr_q == LAST_ADDR);
    assign busy_c = (state_q == ST_RD) || (state_q == ST_LAT) || (state_q == ST_OUT);

    // State and output registers; synchronous reset aborts any in-flight fetch.
    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            state_q   <= ST_IDLE;
            addr_q    <= '0;
            bram_en_q <= 1'b0;
            sample_q  <= '0;
            valid_q   <= 1'b0;
            done_q    <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            bram_en_q <= bram_en_d;
            sample_q  <= sample_d;
            valid_q   <= valid_d;
            done_q    <= done_d;
            overrun_q <= overrun_d;
        end
    end

    // Next-state and next-output logic for fetch, capture, handshake and end of pass.
    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        bram_en_d = 1'b0;
        sample_d  = sample_q;
        valid_d   = valid_q;
        done_d    = (LOOP == 0) ? done_q : 1'b0;
        overrun_d = overrun_q;

        case (state_q)
            ST_IDLE: begin
                if (i_tick && i_enable) begin
                    state_d   = ST_RD;
                    bram_en_d = 1'b1;
                end
            end
            ST_RD: begin
                state_d = ST_LAT;
            end
            ST_LAT: begin
                sample_d = i_bram_data;
                valid_d  = 1'b1;
                state_d  = ST_OUT;
            end
            ST_OUT: begin
                if (xfer_c) begin
                    valid_d = 1'b0;
                    addr_d  = last_c ? '0 : addr_q + 1'b1;
                    done_d  = last_c;
                    state_d = (last_c && (LOOP == 0)) ? ST_DONE : ST_IDLE;
                end
            end
            ST_DONE: begin
                done_d = 1'b1;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // A tick while a fetch or transfer is pending is lost; remember it.
        if (i_tick && busy_c) begin
            overrun_d = 1'b1;
        end
    end

    assign o_bram_en   = bram_en_q;
    assign o_bram_addr = addr_q;
    assign o_sample    = sample_q;
    assign o_valid     = valid_q;
    assign o_done      = done_q;
    assign o_overrun   = overrun_q;

endmodule : bram_sample_streamer

// File: tb/tb_bram_sample_streamer.sv
// Scoreboard bench: instance A loops over 4 samples, instance B plays 4 samples once.
module tb_bram_sample_streamer;

    localparam int unsigned DW  = 16;
    localparam int unsigned AW  = 10;
    localparam int unsigned DEP = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Instance A signals (LOOP=1)
    logic          rstn_a, tick_a, en_a, ready_a;
    logic          bram_en_a, valid_a, done_a, overrun_a;
    logic [AW-1:0] addr_a;
    logic [DW-1:0] bram_data_a, sample_a;

    // Instance B signals (LOOP=0)
    logic          rstn_b, tick_b, en_b, ready_b;
    logic          bram_en_b, valid_b, done_b, overrun_b;
    logic [AW-1:0] addr_b;
    logic [DW-1:0] bram_data_b, sample_b;

    logic [DW-1:0] mem_a [0:DEP-1];
    logic [DW-1:0] mem_b [0:DEP-1];

    bram_sample_streamer #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(DEP), .LOOP(1)) u_loop (
        .i_clk(clk), .i_rstn(rstn_a), .i_tick(tick_a), .i_enable(en_a),
        .o_bram_en(bram_en_a), .o_bram_addr(addr_a), .i_bram_data(bram_data_a),
        .o_sample(sample_a), .o_valid(valid_a), .i_ready(ready_a),
        .o_done(done_a), .o_overrun(overrun_a)
    );

    bram_sample_streamer #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(DEP), .LOOP(0)) u_once (
        .i_clk(clk), .i_rstn(rstn_b), .i_tick(tick_b), .i_enable(en_b),
        .o_bram_en(bram_en_b), .o_bram_addr(addr_b), .i_bram_data(bram_data_b),
        .o_sample(sample_b), .o_valid(valid_b), .i_ready(ready_b),
        .o_done(done_b), .o_overrun(overrun_b)
    );

    // Synchronous-read BRAM models
    always @(posedge clk) if (bram_en_a) bram_data_a <= mem_a[addr_a[1:0]];
    always @(posedge clk) if (bram_en_b) bram_data_b <= mem_b[addr_b[1:0]];

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Scoreboard A
    logic [DW-1:0] q_a[$];
    logic [1:0]    exp_addr_a = 2'd0;
    logic          exp_done_a = 1'b0;
    int            fetch_a = 0, xfer_a = 0, done_cnt_a = 0;

    always @(negedge clk) begin
        if (!rstn_a) begin
            q_a.delete();
            exp_addr_a = 2'd0;
            exp_done_a = 1'b0;
        end else begin
            if (done_a || exp_done_a) check("done_pulse_a", 32'(done_a), 32'(exp_done_a));
            if (done_a) done_cnt_a++;
            exp_done_a = 1'b0;
            if (bram_en_a) begin
                check("fetch_addr_a", 32'(addr_a), 32'(exp_addr_a));
                q_a.push_back(mem_a[exp_addr_a]);
                fetch_a++;
            end
            if (valid_a && ready_a) begin
                if (q_a.size() > 0) check("sample_a", 32'(sample_a), 32'(q_a.pop_front()));
                else check("sample_a_queued", 32'(q_a.size()), 32'd1);
                exp_done_a = (exp_addr_a == 2'd3);
                exp_addr_a = exp_addr_a + 2'd1;
                xfer_a++;
            end
        end
    end

    // Scoreboard B
    logic [DW-1:0] q_b[$];
    logic [1:0]    exp_addr_b = 2'd0;
    logic          exp_done_b = 1'b0;
    int            fetch_b = 0, xfer_b = 0;

    always @(negedge clk) begin
        if (!rstn_b) begin
            q_b.delete();
            exp_addr_b = 2'd0;
            exp_done_b = 1'b0;
        end else begin
            if (done_b || exp_done_b) check("done_level_b", 32'(done_b), 32'(exp_done_b));
            if (bram_en_b) begin
                check("fetch_addr_b", 32'(addr_b), 32'(exp_addr_b));
                q_b.push_back(mem_b[exp_addr_b]);
                fetch_b++;
            end
            if (valid_b && ready_b) begin
                if (q_b.size() > 0) check("sample_b", 32'(sample_b), 32'(q_b.pop_front()));
                else check("sample_b_queued", 32'(q_b.size()), 32'd1);
                if (exp_addr_b == 2'd3) exp_done_b = 1'b1;
                exp_addr_b = exp_addr_b + 2'd1;
                xfer_b++;
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic reset_a();
        rstn_a = 1'b0;
        tick_a = 1'b0;
        cyc(2);
        check("rst_en_a",      32'(bram_en_a), 32'd0);
        check("rst_addr_a",    32'(addr_a),    32'd0);
        check("rst_valid_a",   32'(valid_a),   32'd0);
        check("rst_sample_a",  32'(sample_a),  32'd0);
        check("rst_done_a",    32'(done_a),    32'd0);
        check("rst_overrun_a", 32'(overrun_a), 32'd0);
        rstn_a = 1'b1;
    endtask

    task automatic tick_pulse_a();
        tick_a = 1'b1;
        cyc(1);
        tick_a = 1'b0;
    endtask

    task automatic tick_pulse_b();
        tick_b = 1'b1;
        cyc(1);
        tick_b = 1'b0;
    endtask

    task automatic wait_valid_a(input int lim);
        int n;
        n = 0;
        while (!valid_a && n < lim) begin
            cyc(1);
            n++;
        end
        check("wait_valid_a", 32'(valid_a), 32'd1);
    endtask

    initial begin
        int f0, x0, d0;
        mem_a[0] = 16'h1234; mem_a[1] = 16'hBEEF; mem_a[2] = 16'h8001; mem_a[3] = 16'h7FFE;
        mem_b[0] = 16'hA5A5; mem_b[1] = 16'h0001; mem_b[2] = 16'hFFFF; mem_b[3] = 16'h5A5A;
        rstn_a = 1'b0; tick_a = 1'b0; en_a = 1'b1; ready_a = 1'b1;
        rstn_b = 1'b0; tick_b = 1'b0; en_b = 1'b1; ready_b = 1'b1;

        // 1: single tick latency
        reset_a();
        tick_a = 1'b1;
        cyc(1);
        tick_a = 1'b0;
        check("t1_bram_en_t1", 32'(bram_en_a), 32'd1);
        check("t1_addr_t1",    32'(addr_a),    32'd0);
        cyc(1);
        check("t1_valid_t2",   32'(valid_a),   32'd0);
        cyc(1);
        check("t1_valid_t3",   32'(valid_a),   32'd1);
        check("t1_sample_t3",  32'(sample_a),  32'h1234);
        cyc(1);
        check("t1_valid_t4",   32'(valid_a),   32'd0);
        check("t1_addr_t4",    32'(addr_a),    32'd1);

        // 2: back-pressure
        reset_a();
        ready_a = 1'b0;
        tick_pulse_a();
        wait_valid_a(8);
        for (int i = 0; i < 10; i++) begin
            check("t2_hold_valid",  32'(valid_a),  32'd1);
            check("t2_hold_sample", 32'(sample_a), 32'(mem_a[0]));
            check("t2_hold_addr",   32'(addr_a),   32'd0);
            cyc(1);
        end
        x0 = xfer_a;
        ready_a = 1'b1;
        cyc(1);
        check("t2_valid_after", 32'(valid_a), 32'd0);
        check("t2_addr_after",  32'(addr_a),  32'd1);
        cyc(3);
        check("t2_one_xfer", 32'(xfer_a - x0), 32'd1);

        // 3: looping playback with wrap
        reset_a();
        f0 = fetch_a; x0 = xfer_a; d0 = done_cnt_a;
        repeat (5) begin
            tick_pulse_a();
            cyc(5);
        end
        check("t3_fetches",  32'(fetch_a - f0),    32'd5);
        check("t3_xfers",    32'(xfer_a - x0),     32'd5);
        check("t3_done_cnt", 32'(done_cnt_a - d0), 32'd1);
        check("t3_overrun",  32'(overrun_a),       32'd0);
        check("t3_addr_end", 32'(addr_a),          32'd1);

        // 4: single pass stops in DONE
        cyc(1);
        rstn_b = 1'b1;
        repeat (6) begin
            tick_pulse_b();
            cyc(5);
        end
        check("t4_fetches", 32'(fetch_b),   32'd4);
        check("t4_xfers",   32'(xfer_b),    32'd4);
        check("t4_done",    32'(done_b),    32'd1);
        check("t4_overrun", 32'(overrun_b), 32'd0);
        cyc(10);
        check("t4_done_held", 32'(done_b), 32'd1);
        check("t4_no_fetch",  32'(fetch_b), 32'd4);

        // 5: overrun and disabled ticks
        reset_a();
        f0 = fetch_a;
        tick_a = 1'b1; cyc(1);
        tick_a = 1'b0; cyc(1);
        tick_a = 1'b1; cyc(1);
        tick_a = 1'b0;
        cyc(6);
        check("t5_one_fetch", 32'(fetch_a - f0), 32'd1);
        check("t5_overrun",   32'(overrun_a),    32'd1);
        cyc(10);
        check("t5_overrun_sticky", 32'(overrun_a), 32'd1);
        en_a = 1'b0;
        f0 = fetch_a;
        repeat (3) begin
            tick_pulse_a();
            cyc(5);
        end
        check("t5_disabled_fetch", 32'(fetch_a - f0), 32'd0);
        check("t5_disabled_valid", 32'(valid_a),      32'd0);
        en_a = 1'b1;
        x0 = xfer_a;
        tick_a = 1'b1; cyc(1);
        tick_a = 1'b0; en_a = 1'b0;
        cyc(6);
        check("t5_enable_drop_completes", 32'(xfer_a - x0), 32'd1);
        en_a = 1'b1;

        // 6: reset during LAT
        reset_a();
        repeat (2) begin
            tick_pulse_a();
            cyc(5);
        end
        check("t6_addr_pre", 32'(addr_a), 32'd2);
        tick_a = 1'b1; cyc(1);
        tick_a = 1'b1; cyc(1);
        tick_a = 1'b0;
        check("t6_overrun_pre", 32'(overrun_a), 32'd1);
        rstn_a = 1'b0;
        cyc(1);
        check("t6_valid",   32'(valid_a),   32'd0);
        check("t6_addr",    32'(addr_a),    32'd0);
        check("t6_overrun", 32'(overrun_a), 32'd0);
        check("t6_bram_en", 32'(bram_en_a), 32'd0);
        rstn_a = 1'b1;
        cyc(1);
        tick_pulse_a();
        check("t6_refetch_en",   32'(bram_en_a), 32'd1);
        check("t6_refetch_addr", 32'(addr_a),    32'd0);
        cyc(5);
        check("t6_final_addr", 32'(addr_a), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_bram_sample_streamer
